// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard: shift-tracks in-flight GPR writes, forwards from the youngest
// producing stage, and stalls on load-use / busy HI/LO. Optional perf counters: SB_PERF_CNT_EN.

module id_hazard_port #(
    parameter int PIPE_DEPTH = 3,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int RDY_W      = 2
) (
    input  logic                                 rd_en,
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  logic [DATA_W-1:0]                    rf_rdata,
    input  logic [DATA_W-1:0]                    imm,
    input  logic [PIPE_DEPTH-1:0]                slot_vld,
    input  logic [PIPE_DEPTH-1:0][ADDR_W-1:0]    slot_addr,
    input  logic [PIPE_DEPTH-1:0][RDY_W-1:0]     slot_rdy,
    input  logic [PIPE_DEPTH-1:0][DATA_W-1:0]    st_wdata,
    output logic [DATA_W-1:0]                    opnd,
    output logic                                 hazard
);
    logic found;

    // Ascending search so the youngest in-flight producer shadows older ones.
    always_comb begin
        found  = 1'b0;
        hazard = 1'b0;
        opnd   = rf_rdata;
        if (!rd_en) begin
            opnd = imm;
        end else if (rd_addr == '0) begin
            opnd = '0;
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (!found && slot_vld[k] && slot_addr[k] == rd_addr) begin
                    found = 1'b1;
                    if (slot_rdy[k] <= RDY_W'(k)) opnd = st_wdata[k];
                    else hazard = 1'b1;
                end
            end
        end
    end
endmodule

module id_hazard_scoreboard #(
    parameter int NUM_RD_PORTS = 2,
    parameter int PIPE_DEPTH   = 3,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int MAX_LAT      = 32,
    localparam int RDY_W       = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1,
    localparam int LAT_W       = $clog2(MAX_LAT + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             id_valid_i,
    input  logic                             flush_i,
    input  logic                             pipe_hold_i,
    input  logic [NUM_RD_PORTS-1:0]          rd_en_i,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0]   rd_addr_i,
    input  logic [NUM_RD_PORTS*DATA_W-1:0]   rf_rdata_i,
    input  logic [DATA_W-1:0]                imm_i,
    input  logic                             wr_en_i,
    input  logic [ADDR_W-1:0]                wr_addr_i,
    input  logic [RDY_W-1:0]                 ready_stg_i,
    input  logic [PIPE_DEPTH*DATA_W-1:0]     st_wdata_i,
    input  logic                             long_op_i,
    input  logic [LAT_W-1:0]                 long_lat_i,
    input  logic                             hilo_rd_i,
    output logic [NUM_RD_PORTS*DATA_W-1:0]   opnd_o,
    output logic                             stall_o,
    output logic                             hilo_busy_o
`ifdef SB_PERF_CNT_EN
    ,
    output logic [31:0]                      stall_cnt_o,
    output logic [31:0]                      hilo_stall_cnt_o
`endif
);
    logic [PIPE_DEPTH-1:0]                 vld_pipe;
    logic [PIPE_DEPTH-1:0][ADDR_W-1:0]     addr_pipe;
    logic [PIPE_DEPTH-1:0][RDY_W-1:0]      rdy_pipe;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0]   opnd_raw;
    logic [NUM_RD_PORTS-1:0]               port_haz;
    logic [LAT_W-1:0]                      hilo_cnt;
    logic                                  hilo_haz;
    logic                                  stall_raw;
    logic                                  issue;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        id_hazard_port #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .ADDR_W     (ADDR_W),
            .DATA_W     (DATA_W),
            .RDY_W      (RDY_W)
        ) u_port (
            .rd_en     (rd_en_i[p]),
            .rd_addr   (rd_addr_i[p*ADDR_W +: ADDR_W]),
            .rf_rdata  (rf_rdata_i[p*DATA_W +: DATA_W]),
            .imm       (imm_i),
            .slot_vld  (vld_pipe),
            .slot_addr (addr_pipe),
            .slot_rdy  (rdy_pipe),
            .st_wdata  (st_wdata_i),
            .opnd      (opnd_raw[p]),
            .hazard    (port_haz[p])
        );
    end

    assign hilo_busy_o = (hilo_cnt != '0);
    assign hilo_haz    = hilo_busy_o & (hilo_rd_i | long_op_i);
    assign stall_raw   = id_valid_i & ~flush_i & ((|port_haz) | hilo_haz);
    assign issue       = id_valid_i & ~flush_i & ~stall_raw & ~pipe_hold_i;

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign stall_o = rst & stall_raw;
    assign opnd_o  = rst ? opnd_raw : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            rdy_pipe  <= '0;
        end else if (!pipe_hold_i) begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                addr_pipe[k] <= addr_pipe[k-1];
                rdy_pipe[k]  <= rdy_pipe[k-1];
            end
            vld_pipe[0]  <= issue & wr_en_i & (wr_addr_i != '0);
            addr_pipe[0] <= wr_addr_i;
            rdy_pipe[0]  <= ready_stg_i;
        end
    end

    // The HI/LO unit runs on its own, so the countdown ignores pipe_hold_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        hilo_cnt <= '0;
        else if (issue && long_op_i)     hilo_cnt <= long_lat_i;
        else if (hilo_cnt != '0)         hilo_cnt <= hilo_cnt - LAT_W'(1);
    end

`ifdef SB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o      <= '0;
            hilo_stall_cnt_o <= '0;
        end else if (stall_raw && !pipe_hold_i) begin
            if (stall_cnt_o != '1)                  stall_cnt_o      <= stall_cnt_o + 32'd1;
            if (hilo_haz && hilo_stall_cnt_o != '1) hilo_stall_cnt_o <= hilo_stall_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: stimulus queues expected results, a negedge
// monitor pops and compares them against the DUT.

module tb_id_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, flush, hold, wr_en, long_op, hilo_rd;
    logic [1:0]  rd_en, rdy;
    logic [4:0]  ra0, ra1, wr_addr;
    logic [31:0] rf0, rf1, imm, sw0, sw1, sw2;
    logic [5:0]  lat;
    logic [63:0] opnd;
    logic        stall, busy;
`ifdef SB_PERF_CNT_EN
    logic [31:0] stall_cnt, hilo_stall_cnt;
`endif

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        logic        c0;
        logic [31:0] o0;
        logic        c1;
        logic [31:0] o1;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid_i  (id_valid),
        .flush_i     (flush),
        .pipe_hold_i (hold),
        .rd_en_i     (rd_en),
        .rd_addr_i   ({ra1, ra0}),
        .rf_rdata_i  ({rf1, rf0}),
        .imm_i       (imm),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .ready_stg_i (rdy),
        .st_wdata_i  ({sw2, sw1, sw0}),
        .long_op_i   (long_op),
        .long_lat_i  (lat),
        .hilo_rd_i   (hilo_rd),
        .opnd_o      (opnd),
        .stall_o     (stall),
        .hilo_busy_o (busy)
`ifdef SB_PERF_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt),
        .hilo_stall_cnt_o (hilo_stall_cnt)
`endif
    );

    task automatic chk(input string name, input string fld, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", name, fld, act, expv);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() != 0) begin
            e = q.pop_front();
            chk(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
            chk(e.name, "busy", {31'd0, busy}, {31'd0, e.busy});
            if (e.c0) chk(e.name, "opnd0", opnd[31:0], e.o0);
            if (e.c1) chk(e.name, "opnd1", opnd[63:32], e.o1);
        end
    end

    task automatic push_exp(input string n, input logic s, input logic b,
                            input logic c0, input logic [31:0] o0,
                            input logic c1, input logic [31:0] o1);
        exp_t e;
        e.name = n; e.stall = s; e.busy = b;
        e.c0 = c0; e.o0 = o0; e.c1 = c1; e.o1 = o1;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; flush = 0; hold = 0; rd_en = 0; ra0 = 0; ra1 = 0;
        rf0 = 0; rf1 = 0; imm = 0; wr_en = 0; wr_addr = 0; rdy = 0;
        sw0 = 0; sw1 = 0; sw2 = 0; long_op = 0; lat = 0; hilo_rd = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;

        // Reset: every output forced to zero
        tick(); idle(); id_valid = 1; rd_en = 2'b10; ra0 = 5'd3; ra1 = 5'd3;
        imm = 32'h5; rf0 = 32'h11; rf1 = 32'h22;
        push_exp("reset_zero", 0, 0, 1, 32'h0, 1, 32'h0);

        // ALU chain: $3 forwarded from EX, MEM, WB then from the register file
        tick(); rst = 1'b1; idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd3; rdy = 2'd0; imm = 32'h77;
        push_exp("alu_issue", 0, 0, 1, 32'h77, 1, 32'h77);
        tick(); idle(); id_valid = 1; rd_en = 2'b11; ra0 = 5'd3; ra1 = 5'd7;
        rf0 = 32'h9999; rf1 = 32'hAAAA; sw0 = 32'h1234;
        push_exp("alu_fwd_ex", 0, 0, 1, 32'h1234, 1, 32'hAAAA);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd3; rf0 = 32'h9999; sw1 = 32'h5555; imm = 32'h77;
        push_exp("alu_fwd_mem", 0, 0, 1, 32'h5555, 1, 32'h77);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd3; rf0 = 32'h9999; sw2 = 32'h6666;
        push_exp("alu_fwd_wb", 0, 0, 1, 32'h6666, 0, 0);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd3; rf0 = 32'h9999;
        sw0 = 32'hBAD0; sw1 = 32'hBAD1; sw2 = 32'hBAD2;
        push_exp("alu_retired", 0, 0, 1, 32'h9999, 0, 0);

        // Load-use: one stall, then forward from MEM
        tick(); idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd4; rdy = 2'd1;
        push_exp("ld_issue", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd4; sw0 = 32'hBAD0; sw1 = 32'hDEADBEEF;
        push_exp("ld_use_stall", 1, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd4; sw0 = 32'hBAD0; sw1 = 32'hDEADBEEF;
        push_exp("ld_use_fwd", 0, 0, 1, 32'hDEADBEEF, 0, 0);
        tick(); idle();
        push_exp("idle_a", 0, 0, 0, 0, 0, 0);

        // Priority: $5 in slots 2 and 0, youngest wins; port 1 disabled
        tick(); idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd5;
        push_exp("prio_w1", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1;
        push_exp("prio_nop", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd5;
        push_exp("prio_w2", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd5; ra1 = 5'd5;
        sw0 = 32'h2; sw1 = 32'hBAD1; sw2 = 32'h1; rf0 = 32'hBAD3; imm = 32'hFFFF8000;
        push_exp("prio_youngest", 0, 0, 1, 32'h2, 1, 32'hFFFF8000);
        tick(); idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd0; rd_en = 2'b01; ra0 = 5'd5;
        sw1 = 32'h3; rf0 = 32'hBAD3;
        push_exp("fwd_mem_5", 0, 0, 1, 32'h3, 0, 0);
        tick(); idle(); id_valid = 1; rd_en = 2'b11; ra0 = 5'd0; ra1 = 5'd0;
        rf0 = 32'h1111; rf1 = 32'h2222; sw0 = 32'hBAD0;
        push_exp("r0_zero", 0, 0, 1, 32'h0, 1, 32'h0);

        // Flush with a pending hazard: no stall, bubble inserted
        tick(); idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd6; rdy = 2'd1;
        push_exp("flush_w", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; flush = 1; rd_en = 2'b01; ra0 = 5'd6;
        push_exp("flush_hazard", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd6; sw0 = 32'hBAD0; sw1 = 32'hF1F1;
        push_exp("after_flush", 0, 0, 1, 32'hF1F1, 0, 0);
        tick(); idle();
        push_exp("idle_b", 0, 0, 0, 0, 0, 0);

        // HI/LO: latency 4 blocks MFHI four cycles
        tick(); idle(); id_valid = 1; long_op = 1; lat = 6'd4;
        push_exp("mult_issue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); idle(); id_valid = 1; hilo_rd = 1;
            push_exp("mfhi_stall", 1, 1, 0, 0, 0, 0);
        end
        tick(); idle(); id_valid = 1; hilo_rd = 1;
        push_exp("mfhi_go", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; long_op = 1; lat = 6'd3;
        push_exp("mult2_issue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); id_valid = 1; long_op = 1; lat = 6'd5;
            push_exp("mult_busy_stall", 1, 1, 0, 0, 0, 0);
        end
        tick(); idle(); id_valid = 1; long_op = 1; lat = 6'd0;
        push_exp("mult_lat0", 0, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; hilo_rd = 1;
        push_exp("lat0_idle", 0, 0, 0, 0, 0, 0);

        // Hold: stall reported, slots frozen for three cycles
        tick(); idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd7; rdy = 2'd1;
        push_exp("hold_w", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); hold = 1; id_valid = 1; rd_en = 2'b01; ra0 = 5'd7; sw1 = 32'h7777;
            push_exp("hold_stall", 1, 0, 0, 0, 0, 0);
        end
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd7; sw1 = 32'h7777;
        push_exp("hold_release_stall", 1, 0, 0, 0, 0, 0);
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd7; sw0 = 32'hBAD0; sw1 = 32'h7777;
        push_exp("hold_fwd", 0, 0, 1, 32'h7777, 0, 0);

        // HI/LO countdown keeps running under hold
        tick(); idle(); id_valid = 1; long_op = 1; lat = 6'd2;
        push_exp("hilo_hold_issue", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(); idle(); hold = 1; id_valid = 1; hilo_rd = 1;
            push_exp("hilo_hold", 1, 1, 0, 0, 0, 0);
        end
        tick(); idle(); id_valid = 1; hilo_rd = 1;
        push_exp("hilo_hold_done", 0, 0, 0, 0, 0, 0);

        // Reset pulse mid-stall, released before any clock edge
        tick(); idle(); id_valid = 1; wr_en = 1; wr_addr = 5'd8; rdy = 2'd1;
        push_exp("rst_w", 0, 0, 0, 0, 0, 0);
        tick(); idle(); hold = 1; id_valid = 1; rd_en = 2'b01; ra0 = 5'd8; rf0 = 32'h8888; imm = 32'h1;
        push_exp("pre_rst_stall", 1, 0, 0, 0, 0, 0);
        tick(); rst = 1'b0;
        push_exp("rst_mid", 0, 0, 1, 32'h0, 1, 32'h0);
        @(negedge clk); #1; rst = 1'b1;
        tick(); idle(); id_valid = 1; rd_en = 2'b01; ra0 = 5'd8; rf0 = 32'h8888;
        push_exp("rst_cleared", 0, 0, 1, 32'h8888, 0, 0);

        tick();
        @(negedge clk); #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage operand forwarding logic.
- Tracks in-flight register writes across PIPE_DEPTH post-ID stages in a shift scoreboard and forwards from the youngest producing stage.
- Stalls ID on load-use and long-latency HI/LO hazards.
- Sits between the ID decoder and the ID/EX register; drives operand data and stall to the pipeline control.

Parameters:
- NUM_RD_PORTS, 2, number of operand read ports.
- PIPE_DEPTH, 3, tracked stages after ID (slot 0 = EX, 1 = MEM, 2 = WB).
- ADDR_W, 5, register address width.
- DATA_W, 32, operand width.
- MAX_LAT, 32, maximum HI/LO unit latency in cycles.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (RST_ENABLE = 0).
- id_valid_i  in  1  ID holds a valid instruction.
- flush_i  in  1  kill the ID instruction this cycle; it is not issued.
- pipe_hold_i  in  1  downstream stall; scoreboard frozen.
- rd_en_i  in  NUM_RD_PORTS  per-port read enable.
- rd_addr_i  in  NUM_RD_PORTS*ADDR_W  per-port source register.
- rf_rdata_i  in  NUM_RD_PORTS*DATA_W  register file data.
- imm_i  in  DATA_W  immediate, used by disabled ports.
- wr_en_i  in  1  ID instruction writes a GPR.
- wr_addr_i  in  ADDR_W  destination register.
- ready_stg_i  in  $clog2(PIPE_DEPTH)  first slot whose output carries the result (0 = ALU, 1 = load).
- st_wdata_i  in  PIPE_DEPTH*DATA_W  result data presented by each slot's stage.
- long_op_i  in  1  ID instruction is MULT/DIV (writes HI/LO).
- long_lat_i  in  $clog2(MAX_LAT+1)  its latency.
- hilo_rd_i  in  1  ID instruction reads HI/LO (MFHI/MFLO).
- opnd_o  out  NUM_RD_PORTS*DATA_W  resolved operands.
- stall_o  out  1  ID must hold.
- hilo_busy_o  out  1  HI/LO unit counter non-zero.

Behaviour:
- Slot state per k: valid, addr, rdy (ready stage).
- Reset: all slots invalid; HI/LO counter = 0. While rst is low, stall_o = 0, hilo_busy_o = 0, opnd_o = 0.
- Issue condition: issue = id_valid_i & ~flush_i & ~stall_o & ~pipe_hold_i.
- If ~pipe_hold_i:
  - slot[k] <= slot[k-1] for k >= 1.
  - slot[0] <= {wr_en_i & (wr_addr_i != 0), wr_addr_i, ready_stg_i} when issue; otherwise a bubble (invalid).
- If pipe_hold_i: all slots hold. The slot at index PIPE_DEPTH-1 retires on shift.
- Port p resolution, combinational, same cycle:
  - rd_en=0 -> imm_i.
  - addr=0 -> 0.
  - Otherwise, search slot 0 to PIPE_DEPTH-1; the first valid address match k wins (youngest priority).
  - On a match with rdy <= k -> st_wdata_i[k]. On a match with rdy > k -> port hazard.
  - No match -> rf_rdata_i[p].
- Port hazard output: opnd_o for that port is don't-care; the bench checks it only when stall_o = 0.
- HI/LO counter:
  - Loads long_lat_i on an issue with long_op_i.
  - Otherwise decrements by 1 each cycle while non-zero, independent of pipe_hold_i.
  - long_lat_i = 0 leaves it idle.
  - hilo_busy_o = (cnt != 0).
- stall_o = id_valid_i & ~flush_i & (any port hazard | (hilo_busy_o & (hilo_rd_i | long_op_i))).
- Simultaneous events:
  - flush_i together with a hazard -> no stall, bubble inserted.
  - pipe_hold_i together with a hazard -> stall_o still reported; no state change.
- Reset mid-operation: all in-flight entries discarded immediately (asynchronous).

Optional Feature:
- Macro: SB_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cnt_o (32 bit): counts cycles with stall_o = 1 and pipe_hold_i = 0.
  - hilo_stall_cnt_o (32 bit): subset of those cycles caused by the HI/LO condition.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined, neither the ports nor the counters exist.

Test Plan:
- ALU chain: issue wr $3 with rdy=0, then read $3 next cycle with st_wdata_i[0]=32'h1234 -> opnd_o=32'h1234, stall_o=0.
- Load-use: issue wr $4 with rdy=1, then read $4 -> stall_o=1 for exactly one cycle with bubble in slot 0; next cycle opnd_o = st_wdata_i[1] = 32'hDEAD_BEEF.
- Priority: $5 in slot 2 (32'h1) and slot 0 (32'h2), both ready -> opnd_o=32'h2.
- $0 and disabled port: read $0 while slot 0 writes $0 -> 0, no stall. Port disabled with imm_i=32'hFFFF_8000 -> 32'hFFFF_8000.
- HI/LO: issue long_op with long_lat_i=4, then MFHI -> stall_o high 4 cycles, then low; a second long_op during busy also stalls.
- Hold/reset: pipe_hold_i=1 for 3 cycles -> slots unchanged. Assert rst mid-stall -> stall_o=0 immediately, scoreboard empty after release.
